module_banco_registros: RTL and testbench
=========================================

# module_banco_registros

Register bank and status-flag register that sits directly upstream of the ALU in the single-cycle processor. It supplies the two operands `ALUA`/`ALUB` from a general-purpose register file and the registered carry/shift flag `ALUFlagIn`. On the clock edge closing each instruction it captures `ALUResult`, `ALUFlags` and `Cero` as write-back. All writes are synchronous; all reads are combinational so the single-cycle datapath closes within one clock.

## Interface
- `N`, 4, data width; matches ALU operand width.
- `R`, 16, number of registers; power of two, ≥2.
- `W`, derived `$clog2(R)`, address width (localparam, not overridable).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RegWrite`  in  1  write enable for register file.
- `FlagWrite`  in  1  write enable for flag register (`Cero`, `ALUFlags`).
- `FlagClear`  in  1  synchronous clear of both flags.
- `AddrA`  in  W  read address for port A.
- `AddrB`  in  W  read address for port B.
- `AddrW`  in  W  write address.
- `DataW`  in  N  write data (ALU result or immediate, muxed outside).
- `ALUFlagsD`  in  1  next carry/shift-out flag from ALU.
- `CeroD`  in  1  next zero flag from ALU.
- `DataA`  out  N  register[AddrA]; drives `ALUA`.
- `DataB`  out  N  register[AddrB]; drives `ALUB`.
- `FlagQ`  out  1  registered carry/shift flag; drives `ALUFlagIn`.
- `CeroQ`  out  1  registered zero flag; consumed by branch logic.

## Operation
- Register 0 is hardwired zero. Reads of address 0 return `'0`. Writes to address 0 are discarded.
- Write: on rising `clk` with `RegWrite`=1 and `AddrW`≠0, register[AddrW] ← `DataW`.
- Read: `DataA`/`DataB` are combinational functions of the address and current register contents. There is no write-through bypass: a same-cycle read of `AddrW` returns the pre-edge value, and the new value appears after the edge.
- Both read ports may address the same register; both return the same value.
- Flag register priority on rising edge:
  - `FlagClear`=1 → `FlagQ`=0, `CeroQ`=0. Clear wins over `FlagWrite`.
  - else `FlagWrite`=1 → `FlagQ`←`ALUFlagsD`, `CeroQ`←`CeroD`.
  - else hold.
- `RegWrite` and `FlagWrite` are independent and may both be active in one cycle. Both updates occur on the same edge.
- Inputs with `X` on an address when the corresponding enable is 0 must not corrupt state.

## Timing
- Reset (`rst_n`=0, any time, asynchronous): all registers `'0`, `FlagQ`=0, `CeroQ`=0. Because reads are combinational, `DataA`/`DataB` become `'0` immediately.
- Reset asserted mid-cycle with `RegWrite`=1: the write is lost and the register stays 0.
- First write is honoured on the first rising edge after `rst_n` deasserts.
- Write-to-read latency is 1 cycle: a value written at edge k is visible on `DataA`/`DataB` during cycle k+1.
- Read latency is 0 cycles (combinational, address to data).
- Flag latency is 1 cycle: the ALU's flags for instruction k appear on `FlagQ`/`CeroQ` during instruction k+1. This supports add-with-carry and shift-with-fill chaining.
- No handshake exists; the block accepts a new instruction every cycle.

## Structure
- Shared package `pkg_procesador` holds:
  - `typedef logic [N-1:0] dato_t`, using the processor-wide N.
  - the ALU opcode localparams, so decoder and ALU share one definition.
  - `localparam REG_CERO = 0`.
- One sub-module is natural: `module_registro_flags`, the 2-bit flag register with clear/enable priority, async active-low reset.
- The register array is a `logic [N-1:0] regs [R]` updated in one `always_ff` with async reset.

## Test plan
- Reset, then read every address on A and B → all read `0`; `FlagQ`=0, `CeroQ`=0.
- Write `4'hA` to r3 with `RegWrite`=1 while reading `AddrA`=3 in the same cycle → `DataA`=0 during the cycle, `4'hA` the next cycle. Then `AddrB`=3 → `DataB`=`4'hA`.
- Write `4'hF` to r0 → `DataA` with `AddrA`=0 remains `0`.
- Apply `ALUFlagsD`=1, `CeroD`=1, `FlagWrite`=1 → both flags 1 next cycle. Then `FlagWrite`=1, `FlagClear`=1 in the same cycle → both flags 0.
- Fill r1..r15 with their own index, then assert `rst_n`=0 mid-cycle with `RegWrite`=1 to r5 → all outputs `0` immediately, with no clock edge required; r5 stays 0 after release.
- Chain test: write r1=`4'hF` and r2=`4'h1`, then drive the ALU externally with `op_suma` → `CeroD`=1, `ALUFlagsD` captured. Next cycle `FlagQ` matches the captured flag and feeds `ALUFlagIn`.

Source files
------------

// File: rtl/module_banco_registros_pkg.sv
// Processor-wide shared definitions: data width, data type, ALU opcodes
// and the hardwired-zero register index. Imported by decoder, ALU and
// register bank so every block agrees on one definition.
package pkg_procesador;

    // Processor-wide datapath width (ALU operand width)
    localparam int unsigned N_PROC = 4;

    typedef logic [N_PROC-1:0] dato_t;

    // ALU opcodes, shared by decoder and ALU
    localparam int unsigned OP_W = 3;
    localparam logic [OP_W-1:0] OP_SUMA  = 3'd0;
    localparam logic [OP_W-1:0] OP_RESTA = 3'd1;
    localparam logic [OP_W-1:0] OP_AND   = 3'd2;
    localparam logic [OP_W-1:0] OP_OR    = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL   = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR   = 3'd6;
    localparam logic [OP_W-1:0] OP_PASA  = 3'd7;

    // Register index that always reads zero and ignores writes
    localparam int unsigned REG_CERO = 0;

endpackage

// File: rtl/module_registro_flags.sv
// 2-bit status flag register (carry/shift flag and zero flag).
// Priority on each rising edge: clear, then load, then hold.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous clear of both flags (wins over enable)
//   enable          load flag_d / cero_d
//   flag_d, cero_d  next flag values from the ALU
//   flag_q, cero_q  registered flags
module module_registro_flags (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic flag_d,
    input  logic cero_d,
    output logic flag_q,
    output logic cero_q
);

    // Flag state with clear > load > hold priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
            cero_q <= 1'b0;
        end else if (clear) begin
            flag_q <= 1'b0;
            cero_q <= 1'b0;
        end else if (enable) begin
            flag_q <= flag_d;
            cero_q <= cero_d;
        end
    end

endmodule

// File: rtl/module_banco_registros.sv
// Register bank and status-flag register feeding the ALU.
// Two combinational read ports, one synchronous write port, register 0
// hardwired to zero, plus the registered carry/shift and zero flags.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   RegWrite              register file write enable
//   FlagWrite, FlagClear  flag register load / synchronous clear
//   AddrA, AddrB, AddrW   read A, read B and write addresses
//   DataW                 write data
//   ALUFlagsD, CeroD      next carry/shift flag and zero flag from ALU
//   DataA, DataB          combinational read data (ALU operands)
//   FlagQ, CeroQ          registered carry/shift flag and zero flag
module module_banco_registros
    import pkg_procesador::*;
#(
    parameter  int unsigned N = N_PROC,
    parameter  int unsigned R = 16,
    localparam int unsigned W = $clog2(R)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         RegWrite,
    input  logic         FlagWrite,
    input  logic         FlagClear,
    input  logic [W-1:0] AddrA,
    input  logic [W-1:0] AddrB,
    input  logic [W-1:0] AddrW,
    input  logic [N-1:0] DataW,
    input  logic         ALUFlagsD,
    input  logic         CeroD,
    output logic [N-1:0] DataA,
    output logic [N-1:0] DataB,
    output logic         FlagQ,
    output logic         CeroQ
);

    localparam logic [W-1:0] ADDR_CERO = W'(REG_CERO);

    logic [N-1:0] regs [R];

    // Register file; the zero register is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(R); i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (AddrW != ADDR_CERO)) begin
            regs[AddrW] <= DataW;
        end
    end

    // Combinational reads, no write-through bypass
    always_comb begin
        DataA = '0;
        DataB = '0;
        if (AddrA != ADDR_CERO) begin
            DataA = regs[AddrA];
        end
        if (AddrB != ADDR_CERO) begin
            DataB = regs[AddrB];
        end
    end

    module_registro_flags u_flags (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (FlagClear),
        .enable (FlagWrite),
        .flag_d (ALUFlagsD),
        .cero_d (CeroD),
        .flag_q (FlagQ),
        .cero_q (CeroQ)
    );

endmodule

// File: tb/tb_module_banco_registros.sv
// Directed self-checking bench for module_banco_registros.
module tb_module_banco_registros;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         RegWrite;
    logic         FlagWrite;
    logic         FlagClear;
    logic [W-1:0] AddrA;
    logic [W-1:0] AddrB;
    logic [W-1:0] AddrW;
    logic [N-1:0] DataW;
    logic         ALUFlagsD;
    logic         CeroD;
    logic [N-1:0] DataA;
    logic [N-1:0] DataB;
    logic         FlagQ;
    logic         CeroQ;

    int checks = 0;
    int errors = 0;

    module_banco_registros #(.N(N), .R(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .FlagWrite (FlagWrite),
        .FlagClear (FlagClear),
        .AddrA     (AddrA),
        .AddrB     (AddrB),
        .AddrW     (AddrW),
        .DataW     (DataW),
        .ALUFlagsD (ALUFlagsD),
        .CeroD     (CeroD),
        .DataA     (DataA),
        .DataB     (DataB),
        .FlagQ     (FlagQ),
        .CeroQ     (CeroQ)
    );

    // 100 time-unit period leaves room for many combinational probes per cycle
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [4:0] suma;

    initial begin
        rst_n     = 1'b0;
        RegWrite  = 1'b0;
        FlagWrite = 1'b0;
        FlagClear = 1'b0;
        AddrA     = '0;
        AddrB     = '0;
        AddrW     = '0;
        DataW     = '0;
        ALUFlagsD = 1'b0;
        CeroD     = 1'b0;
        #20;
        rst_n = 1'b1;
        #10;

        // Reset state on every address
        for (int i = 0; i < 16; i++) begin
            AddrA = 4'(i);
            AddrB = 4'(15 - i);
            #1;
            check($sformatf("rst_a%0d", i), 32'(DataA), 32'h0);
            check($sformatf("rst_b%0d", 15 - i), 32'(DataB), 32'h0);
        end
        check("rst_flagq", 32'(FlagQ), 32'h0);
        check("rst_ceroq", 32'(CeroQ), 32'h0);

        // Write r3 while reading it: old value this cycle, new value next
        tick();
        RegWrite = 1'b1; AddrW = 4'd3; DataW = 4'hA; AddrA = 4'd3;
        #1;
        check("r3_same_cycle", 32'(DataA), 32'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("r3_next_a", 32'(DataA), 32'hA);
        AddrB = 4'd3;
        #1;
        check("r3_next_b", 32'(DataB), 32'hA);
        check("r3_both_a", 32'(DataA), 32'hA);

        // Write to r0 is discarded
        RegWrite = 1'b1; AddrW = 4'd0; DataW = 4'hF;
        tick();
        RegWrite = 1'b0; AddrA = 4'd0;
        #1;
        check("r0_zero", 32'(DataA), 32'h0);

        // Unknown address/data with write disabled must not disturb state
        AddrW = 'x; DataW = 'x;
        tick();
        AddrA = 4'd3;
        #1;
        check("x_addr_hold", 32'(DataA), 32'hA);
        AddrW = '0; DataW = '0;

        // Flag load, hold, then clear beats load
        FlagWrite = 1'b1; ALUFlagsD = 1'b1; CeroD = 1'b1;
        tick();
        check("flag_load_f", 32'(FlagQ), 32'h1);
        check("flag_load_z", 32'(CeroQ), 32'h1);
        FlagWrite = 1'b0; ALUFlagsD = 1'b0; CeroD = 1'b0;
        tick();
        check("flag_hold_f", 32'(FlagQ), 32'h1);
        check("flag_hold_z", 32'(CeroQ), 32'h1);
        FlagWrite = 1'b1; FlagClear = 1'b1; ALUFlagsD = 1'b1; CeroD = 1'b1;
        tick();
        check("flag_clr_f", 32'(FlagQ), 32'h0);
        check("flag_clr_z", 32'(CeroQ), 32'h0);
        FlagClear = 1'b0;
        // Load of mixed values alongside a register write on the same edge
        ALUFlagsD = 1'b1; CeroD = 1'b0;
        RegWrite = 1'b1; AddrW = 4'd7; DataW = 4'h6;
        tick();
        FlagWrite = 1'b0; RegWrite = 1'b0; AddrA = 4'd7;
        #1;
        check("dual_f", 32'(FlagQ), 32'h1);
        check("dual_z", 32'(CeroQ), 32'h0);
        check("dual_r7", 32'(DataA), 32'h6);

        // Fill r1..r15 with their own index
        for (int i = 1; i < 16; i++) begin
            RegWrite = 1'b1; AddrW = 4'(i); DataW = 4'(i);
            tick();
        end
        RegWrite = 1'b0;
        for (int i = 1; i < 16; i++) begin
            AddrA = 4'(i);
            AddrB = 4'(16 - i);
            #1;
            check($sformatf("fill_a%0d", i), 32'(DataA), 32'(i));
            check($sformatf("fill_b%0d", 16 - i), 32'(DataB), 32'(16 - i));
        end

        // Asynchronous reset mid-cycle with a pending write to r5
        tick();
        RegWrite = 1'b1; AddrW = 4'd5; DataW = 4'h9;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_flagq", 32'(FlagQ), 32'h0);
        for (int i = 0; i < 16; i++) begin
            AddrA = 4'(i);
            AddrB = 4'(i);
            #1;
            check($sformatf("arst_a%0d", i), 32'(DataA), 32'h0);
            check($sformatf("arst_b%0d", i), 32'(DataB), 32'h0);
        end
        RegWrite = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        AddrA = 4'd5;
        #1;
        check("r5_after_rst", 32'(DataA), 32'h0);

        // First write after reset release is honoured
        RegWrite = 1'b1; AddrW = 4'd5; DataW = 4'h7;
        tick();
        RegWrite = 1'b0;
        #1;
        check("r5_first_wr", 32'(DataA), 32'h7);

        // Chain: r1=F, r2=1, external add gives 0x10 -> carry 1, zero 1
        RegWrite = 1'b1; AddrW = 4'd1; DataW = 4'hF;
        tick();
        AddrW = 4'd2; DataW = 4'h1;
        tick();
        RegWrite = 1'b0; AddrA = 4'd1; AddrB = 4'd2;
        #1;
        check("chain_a", 32'(DataA), 32'hF);
        check("chain_b", 32'(DataB), 32'h1);
        suma = {1'b0, DataA} + {1'b0, DataB};
        ALUFlagsD = suma[4];
        CeroD = (suma[3:0] == 4'h0);
        FlagWrite = 1'b1;
        tick();
        FlagWrite = 1'b0;
        check("chain_flagq", 32'(FlagQ), 32'h1);
        check("chain_ceroq", 32'(CeroQ), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
